// File: rtl/conv_dma_pkg.sv
// Shared definitions for the convolution-engine DMA controller:
// FSM state codes, default sizing and the word-to-byte address helper.
package conv_dma_pkg;

  localparam int DSIZE_DEF  = 256;
  // Engine ports are byte addressed while the streams move 32-bit words.
  localparam int BYTE_SHIFT = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  // Word index to byte address; callers truncate to their port width,
  // which gives the modulo-2^AW wrap for free.
  function automatic logic [31:0] word2byte(input logic [31:0] w);
    return w << BYTE_SHIFT;
  endfunction

endpackage

// File: rtl/conv_dma_obuf.sv
// Single-entry output register for the drain stream. Once valid, data is
// held until the consumer takes it; a new word may be loaded in the same
// cycle the current one is accepted, which keeps 1 word/cycle throughput.
module conv_dma_obuf #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data
);

  // Capture on load, otherwise drop valid once the word is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/conv_dma_ctrl.sv
// Stream-to-engine DMA initiator: loads the engine input memory from the
// input stream, pulses conv_start, waits for conv_done, then drains the
// engine output memory to the output stream.
// Optional feature macro: CONV_DMA_TIMEOUT_EN adds a RUN watchdog that
// raises the sticky err flag and aborts the job after TIMEOUT_CYC cycles.
module conv_dma_ctrl
  import conv_dma_pkg::*;
#(
  parameter int DSIZE       = DSIZE_DEF,
  parameter int AW          = $clog2(DSIZE) - 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          go,
  input  logic [AW-1:0] in_words,
  input  logic [AW-1:0] out_words,
  output logic          busy,
  output logic          job_done,
  output logic          err,
  input  logic [31:0]   s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [31:0]   m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [AW-1:0] mi_addr,
  output logic [31:0]   mi_data,
  output logic          mi_wr,
  output logic [AW-1:0] mo_addr,
  input  logic [31:0]   mo_data,
  output logic          conv_start,
  input  logic          conv_done
);

  localparam logic [AW-1:0] ONE = AW'(1);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("conv_dma_ctrl: TIMEOUT_CYC must be at least 1");
  end

  logic [2:0]    state, nstate;
  logic [AW-1:0] in_n, out_n;   // job sizes latched at go
  logic [AW-1:0] cnt;           // words accepted (LOAD) / delivered (DRAIN)
  logic [AW-1:0] fcnt;          // words fetched from the engine in DRAIN
  logic          finish;
  logic          drain_hs;
  logic          obuf_load;
  logic          to_hit;

  // Write strobe and start pulse come straight from state and handshake so
  // the engine sees the word in the cycle it is accepted. mi_data is gated
  // so it reads zero whenever no write is in progress.
  assign mi_wr      = (state == ST_LOAD) && s_valid && s_ready;
  assign mi_data    = mi_wr ? s_data : 32'h0;
  assign conv_start = (state == ST_START);
  assign drain_hs   = (state == ST_DRAIN) && m_valid && m_ready;

  // mo_addr runs one word ahead of the delivered count: the next word is
  // fetched while the current one is still on the output port.
  assign obuf_load  = (state == ST_DRAIN) && (fcnt != out_n) && (!m_valid || m_ready);

  conv_dma_obuf #(.W(32)) u_obuf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (obuf_load),
    .din   (mo_data),
    .ready (m_ready),
    .valid (m_valid),
    .data  (m_data)
  );

`ifdef CONV_DMA_TIMEOUT_EN
  logic [31:0] tcnt;

  assign to_hit = (state == ST_RUN) && (tcnt == 32'(TIMEOUT_CYC - 1));

  // Watchdog: counts RUN cycles; err is sticky until the next accepted go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      tcnt <= (state == ST_RUN) ? tcnt + 32'd1 : 32'd0;
      if (state == ST_IDLE && go)
        err <= 1'b0;
      else if (to_hit && !conv_done)
        err <= 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  // Next-state logic; finish marks the transition that ends a job.
  always_comb begin
    nstate = state;
    finish = 1'b0;
    case (state)
      ST_IDLE:  if (go) nstate = (in_words != '0) ? ST_LOAD : ST_START;
      ST_LOAD:  if (mi_wr && cnt == in_n - ONE) nstate = ST_START;
      ST_START: nstate = ST_RUN;
      ST_RUN: begin
        if (conv_done) begin
          if (out_n != '0) begin
            nstate = ST_DRAIN;
          end else begin
            nstate = ST_IDLE;
            finish = 1'b1;
          end
        end else if (to_hit) begin
          nstate = ST_IDLE;
          finish = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (drain_hs && cnt == out_n - ONE) begin
          nstate = ST_IDLE;
          finish = 1'b1;
        end
      end
      default:  nstate = ST_IDLE;
    endcase
  end

  // State, registered status outputs, counters and engine addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      s_ready  <= 1'b0;
      job_done <= 1'b0;
      in_n     <= '0;
      out_n    <= '0;
      cnt      <= '0;
      fcnt     <= '0;
      mi_addr  <= '0;
      mo_addr  <= '0;
    end else begin
      state    <= nstate;
      busy     <= (nstate != ST_IDLE);
      s_ready  <= (nstate == ST_LOAD);
      job_done <= finish;
      case (state)
        ST_IDLE: begin
          if (go) begin
            in_n    <= in_words;
            out_n   <= out_words;
            cnt     <= '0;
            mi_addr <= '0;
          end
        end
        ST_LOAD: begin
          if (mi_wr) begin
            cnt     <= cnt + ONE;
            mi_addr <= AW'(word2byte(32'(cnt + ONE)));
          end
        end
        ST_RUN: begin
          if (conv_done) begin
            cnt     <= '0;
            fcnt    <= '0;
            mo_addr <= '0;
          end
        end
        ST_DRAIN: begin
          if (obuf_load) begin
            fcnt    <= fcnt + ONE;
            mo_addr <= AW'(word2byte(32'(fcnt + ONE)));
          end
          if (drain_hs) cnt <= cnt + ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_dma_ctrl.sv
// Self-checking bench for conv_dma_ctrl with a loopback engine stub
// (input and output memory are the same array) and a word-level model.
module tb_conv_dma_ctrl;

  localparam int DSIZE = 256;
  localparam int AW    = $clog2(DSIZE) - 2;
  localparam int NW    = 2 ** (AW - 2);
  localparam int TO    = 16;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          go = 1'b0, busy, job_done, err;
  logic [AW-1:0] in_words = '0, out_words = '0;
  logic [31:0]   s_data = '0, m_data, mi_data, mo_data;
  logic          s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b0;
  logic [AW-1:0] mi_addr, mo_addr;
  logic          mi_wr, conv_start, conv_done = 1'b0;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  conv_dma_ctrl #(.DSIZE(DSIZE), .AW(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .in_words(in_words), .out_words(out_words),
    .busy(busy), .job_done(job_done), .err(err),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .mi_addr(mi_addr), .mi_data(mi_data), .mi_wr(mi_wr),
    .mo_addr(mo_addr), .mo_data(mo_data),
    .conv_start(conv_start), .conv_done(conv_done)
  );

  // Engine stub: loopback memory, combinational read.
  logic [31:0] emem [NW] = '{default: 32'h0};
  always @(posedge clk) if (mi_wr) emem[mi_addr[AW-1:2]] <= mi_data;
  assign mo_data = emem[mo_addr[AW-1:2]];

  // Reference model: the engine memory seen as NW words, plus job words.
  logic [31:0] mdl  [NW] = '{default: 32'h0};
  logic [31:0] wbuf [64];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Observed traffic.
  logic [31:0] wa_q [$];
  logic [31:0] wd_q [$];
  logic [31:0] od_q [$];
  int cs_n, jd_n, sr_n, mv_n;
  logic pv = 1'b0, pr = 1'b0;
  logic [31:0] pd = '0;

  // Monitor: record writes/reads/pulses and check output hold under stall.
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0; pr = 1'b0; pd = '0;
    end else begin
      if (mi_wr) begin wa_q.push_back(32'(mi_addr)); wd_q.push_back(mi_data); end
      if (m_valid && m_ready) od_q.push_back(m_data);
      if (pv && !pr) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_data", m_data, pd);
      end
      cs_n += int'(conv_start); jd_n += int'(job_done);
      sr_n += int'(s_ready);    mv_n += int'(m_valid);
      pv = m_valid; pr = m_ready; pd = m_data;
    end
  end

  task automatic clr();
    wa_q.delete(); wd_q.delete(); od_q.delete();
    cs_n = 0; jd_n = 0; sr_n = 0; mv_n = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);       chk({tag, "_done"}, 32'(job_done), 0);
    chk({tag, "_err"}, 32'(err), 0);         chk({tag, "_sready"}, 32'(s_ready), 0);
    chk({tag, "_mvalid"}, 32'(m_valid), 0);  chk({tag, "_mdata"}, m_data, 0);
    chk({tag, "_miwr"}, 32'(mi_wr), 0);      chk({tag, "_miaddr"}, 32'(mi_addr), 0);
    chk({tag, "_midata"}, mi_data, 0);       chk({tag, "_moaddr"}, 32'(mo_addr), 0);
    chk({tag, "_start"}, 32'(conv_start), 0);
  endtask

  // Present n words from wbuf; vmode 0 = always valid, 1 = toggle, 2 = random.
  task automatic feed(input int n, input int vmode, output int lc);
    int idx = 0;
    bit tog = 1'b1, acc;
    lc = 0;
    while (idx < n && lc < 1000) begin
      case (vmode)
        0:       s_valid = 1'b1;
        1:       begin s_valid = tog; tog = !tog; end
        default: s_valid = 1'($urandom_range(0, 1));
      endcase
      s_data = wbuf[idx];
      @(negedge clk); acc = s_valid && s_ready;
      @(posedge clk); #1; lc++;
      if (acc) idx++;
    end
    if (idx < n) chk("load_timeout", 32'(idx), 32'(n));
  endtask

  // Compare a finished job against the model and fold its writes in.
  task automatic post(input int in_n, input int out_n);
    chk("wr_count", 32'(wd_q.size()), 32'(in_n));
    for (int i = 0; i < in_n && i < wd_q.size(); i++) begin
      chk("wr_addr", wa_q[i], 32'((i * 4) % (1 << AW)));
      chk("wr_data", wd_q[i], wbuf[i]);
    end
    for (int i = 0; i < in_n; i++) mdl[i % NW] = wbuf[i];
    chk("rd_count", 32'(od_q.size()), 32'(out_n));
    for (int i = 0; i < out_n && i < od_q.size(); i++)
      chk("rd_data", od_q[i], mdl[i % NW]);
    chk("start_pulses", 32'(cs_n), 32'd1);
    chk("done_pulses", 32'(jd_n), 32'd1);
  endtask

  // One full job; caller is at posedge+1 with the DUT idle.
  task automatic run_job(input int in_n, input int out_n, input int vmode,
                         input int rmode, input bit go_run);
    int lc, dc;
    clr();
    go = 1'b1; in_words = AW'(in_n); out_words = AW'(out_n);
    @(posedge clk); #1; go = 1'b0;
    chk("busy_go", 32'(busy), 1);
    chk("sready_go", 32'(s_ready), 32'(in_n != 0));
    chk("err_clr", 32'(err), 0);
    feed(in_n, vmode, lc);
    s_valid = 1'b0;
    if (vmode == 0) chk("load_rate", 32'(lc), 32'(in_n));
    chk("start_hi", 32'(conv_start), 1);
    @(posedge clk); #1;
    chk("start_lo", 32'(conv_start), 0);
    if (go_run) begin
      go = 1'b1; in_words = AW'($urandom); out_words = AW'($urandom);
      @(posedge clk); #1; go = 1'b0;
      chk("go_ign_busy", 32'(busy), 1);
      chk("go_ign_sready", 32'(s_ready), 0);
    end
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    conv_done = 1'b1;
    @(posedge clk); #1; conv_done = 1'b0;
    if (out_n == 0) begin
      chk("done_nodrain", 32'(job_done), 1);
      chk("busy_nodrain", 32'(busy), 0);
    end else begin
      chk("drain_entry", 32'(m_valid), 0);
      dc = 0;
      while (!job_done && dc < 2000) begin
        case (rmode)
          0:       m_ready = 1'b1;
          1:       m_ready = 1'($urandom_range(0, 1));
          default: m_ready = !(dc >= 2 && dc < 7);
        endcase
        @(posedge clk); #1; dc++;
        if (dc == 1) chk("first_mvalid", 32'(m_valid), 1);
      end
      m_ready = 1'b0;
      chk("done_drain", 32'(job_done), 1);
      chk("busy_drain", 32'(busy), 0);
      if (rmode == 0) chk("drain_rate", 32'(dc), 32'(out_n + 1));
    end
    @(posedge clk); #1;
    chk("done_1cyc", 32'(job_done), 0);
    post(in_n, out_n);
    if (in_n == 0 && out_n == 0) begin
      chk("zero_sready_cyc", 32'(sr_n), 0);
      chk("zero_mvalid_cyc", 32'(mv_n), 0);
    end
  endtask

  initial begin
    int lc, n;
    #12;
    chk_reset_vals("rst");
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed loopback of four words.
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h11111111 * (i + 1);
    run_job(4, 4, 0, 0, 1'b0);
    // Toggling s_valid over eight words.
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    run_job(8, 8, 1, 0, 1'b0);
    // Five-cycle m_ready stall mid-drain.
    for (int i = 0; i < 6; i++) wbuf[i] = $urandom;
    run_job(6, 6, 0, 2, 1'b0);
    // go during RUN.
    for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
    run_job(3, 5, 0, 0, 1'b1);
    // Empty job.
    run_job(0, 0, 0, 0, 1'b0);
    // Randomized jobs, sizes past engine capacity to exercise the wrap.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
      run_job($urandom_range(1, 20), $urandom_range(1, 20),
              $urandom_range(0, 2), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

`ifdef CONV_DMA_TIMEOUT_EN
    // Watchdog: conv_done never arrives.
    clr();
    wbuf[0] = $urandom;
    go = 1'b1; in_words = AW'(1); out_words = AW'(2);
    @(posedge clk); #1; go = 1'b0;
    feed(1, 0, lc);
    s_valid = 1'b0;
    chk("to_start", 32'(conv_start), 1);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!job_done && n < 200);
    chk("to_cycles", 32'(n), 32'(TO + 1));
    chk("to_err", 32'(err), 1);
    chk("to_busy", 32'(busy), 0);
    repeat (3) begin @(posedge clk); #1; end
    chk("to_err_sticky", 32'(err), 1);
    chk("to_nodrain", 32'(od_q.size()), 0);
    chk("to_wr", 32'(wd_q.size()), 1);
    mdl[0] = wbuf[0];
    // Next job clears err (checked inside run_job).
    for (int i = 0; i < 2; i++) wbuf[i] = $urandom;
    run_job(2, 2, 0, 0, 1'b0);
`endif

    // Reset in the middle of LOAD.
    clr();
    for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
    go = 1'b1; in_words = AW'(8); out_words = AW'(8);
    @(posedge clk); #1; go = 1'b0;
    feed(3, 0, lc);
    rst_n = 1'b0; #1;
    chk_reset_vals("midrst");
    s_valid = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_wr", 32'(wd_q.size()), 3);
    for (int i = 0; i < 3 && i < wd_q.size(); i++) begin
      chk("midrst_addr", wa_q[i], 32'(i * 4));
      chk("midrst_data", wd_q[i], wbuf[i]);
    end
    for (int i = 0; i < 3; i++) mdl[i] = wbuf[i];
    chk("midrst_idle", 32'(busy), 0);

    // Recovery job after reset.
    for (int i = 0; i < 5; i++) wbuf[i] = $urandom;
    run_job(5, 7, 2, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
